// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that detect
// decode read hazards, with same-cycle writeback bypass and a stall counter.
module reg_scoreboard #(
  parameter  int W_RN  = 3,
  parameter  int W_CNT = 2,
  localparam int NREG  = 2 ** W_RN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_v_i,
  input  logic [W_RN-1:0]   set_num_i,
  input  logic              clr_v_i,
  input  logic [W_RN-1:0]   clr_num_i,
  input  logic [W_RN-1:0]   r0_num_i,
  input  logic [W_RN-1:0]   r1_num_i,
  input  logic              r0_use_i,
  input  logic              r1_use_i,
  input  logic              flush_i,
  output logic              reserved_o,
  output logic              set_ack_o,
  output logic [NREG-1:0]   busy_o,
  output logic              err_o,
  output logic [15:0]       stall_cnt_o
);

  localparam logic [W_CNT-1:0] CMAX = '1;

  logic [W_CNT-1:0] cnt_q [NREG];
  logic [W_CNT-1:0] cnt_d [NREG];
  logic             err_q, err_d;
  logic [15:0]      stall_q, stall_d;

  logic             same_reg;
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic [NREG-1:0]  eff_busy;
  logic             hz0, hz1;

  always_comb begin
    same_reg  = set_v_i & clr_v_i & (set_num_i == clr_num_i);
    // A full counter may still accept a set when the same register retires now.
    set_ack_o = set_v_i & ~flush_i & ((cnt_q[set_num_i] != CMAX) | same_reg);

    inc_vec  = '0;
    dec_vec  = '0;
    eff_busy = '0;
    busy_o   = '0;
    for (int n = 0; n < NREG; n++) begin
      cnt_d[n]    = cnt_q[n];
      inc_vec[n]  = set_ack_o & (set_num_i == W_RN'(n));
      dec_vec[n]  = clr_v_i & (clr_num_i == W_RN'(n));
      busy_o[n]   = (cnt_q[n] != '0);
      // The register file writes through, so the last retiring write is bypassed.
      eff_busy[n] = (cnt_q[n] != '0) & ~(dec_vec[n] & (cnt_q[n] == W_CNT'(1)));

      if (flush_i) begin
        cnt_d[n] = '0;
      end else if (inc_vec[n] && !dec_vec[n]) begin
        cnt_d[n] = cnt_q[n] + W_CNT'(1);
      end else if (dec_vec[n] && !inc_vec[n] && (cnt_q[n] != '0)) begin
        cnt_d[n] = cnt_q[n] - W_CNT'(1);
      end
    end

    hz0        = r0_use_i & eff_busy[r0_num_i];
    hz1        = r1_use_i & eff_busy[r1_num_i];
    reserved_o = (hz0 | hz1) & ~flush_i;

    // A flush discards the clear, so an underflowing clear under flush is not an error.
    err_d   = err_q | (~flush_i & clr_v_i & (cnt_q[clr_num_i] == '0));
    stall_d = (reserved_o && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
  end

  // NOTE: the counter array is small control state and must be cleared on reset,
  // unlike data memories; a loop in the reset branch keeps it flop-based.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NREG; n++) cnt_q[n] <= '0;
      err_q   <= 1'b0;
      stall_q <= 16'd0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign err_o       = err_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard with default parameters
// (8 registers, 2-bit counters, CMAX = 3).
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_v_i, clr_v_i, r0_use_i, r1_use_i, flush_i;
  logic [2:0]  set_num_i, clr_num_i, r0_num_i, r1_num_i;
  logic        reserved_o, set_ack_o, err_o;
  logic [7:0]  busy_o;
  logic [15:0] stall_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  reg_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .set_v_i    (set_v_i),
    .set_num_i  (set_num_i),
    .clr_v_i    (clr_v_i),
    .clr_num_i  (clr_num_i),
    .r0_num_i   (r0_num_i),
    .r1_num_i   (r1_num_i),
    .r0_use_i   (r0_use_i),
    .r1_use_i   (r1_use_i),
    .flush_i    (flush_i),
    .reserved_o (reserved_o),
    .set_ack_o  (set_ack_o),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_v_i = 0; clr_v_i = 0; flush_i = 0; r0_use_i = 0; r1_use_i = 0;
    set_num_i = 0; clr_num_i = 0; r0_num_i = 0; r1_num_i = 0;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    // Under reset: state is zero, combinational outputs still evaluate.
    set_v_i = 1; set_num_i = 3; r0_use_i = 1; r0_num_i = 3;
    #12;
    check("rst_busy", busy_o, 8'h00);
    check("rst_err", err_o, 0);
    check("rst_stall", stall_cnt_o, 0);
    check("rst_reserved", reserved_o, 0);
    check("rst_set_ack", set_ack_o, 1);
    tick();
    check("rst_hold_busy", busy_o, 8'h00);
    idle();
    #2 rst = 1'b1;
    tick();

    // Single reservation of r3 with writeback bypass.
    set_v_i = 1; set_num_i = 3; r0_use_i = 1; r0_num_i = 3;
    #1;
    check("r3_set_ack", set_ack_o, 1);
    check("r3_set_no_self_hazard", reserved_o, 0);
    tick();
    set_v_i = 0;
    #1;
    check("r3_reserved", reserved_o, 1);
    check("r3_busy", busy_o, 8'h08);
    tick();
    clr_v_i = 1; clr_num_i = 3;
    #1;
    check("r3_bypass", reserved_o, 0);
    check("r3_busy_until_edge", busy_o, 8'h08);
    tick();
    idle();
    #1;
    check("r3_cleared", busy_o, 8'h00);
    check("stall_one", stall_cnt_o, 1);

    // Saturation of r5 at CMAX.
    for (int i = 0; i < 3; i++) begin
      set_v_i = 1; set_num_i = 5;
      #1;
      check($sformatf("r5_set%0d_ack", i), set_ack_o, 1);
      tick();
    end
    #1;
    check("r5_busy", busy_o, 8'h20);
    check("r5_full_nack", set_ack_o, 0);
    tick();
    clr_v_i = 1; clr_num_i = 5;
    #1;
    check("r5_full_with_clear_ack", set_ack_o, 1);
    tick();
    set_v_i = 0;
    // Exactly three clears must drain it: proves the count stayed at 3.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("r5_drain%0d", i), busy_o, (i < 2) ? 8'h20 : 8'h00);
    end
    idle();
    #1;
    check("r5_no_err", err_o, 0);

    // Same-register set and clear with cnt = 1, then underflow error.
    set_v_i = 1; set_num_i = 2;
    tick();
    clr_v_i = 1; clr_num_i = 2;
    #1;
    check("r2_setclr_ack", set_ack_o, 1);
    tick();
    idle();
    r0_use_i = 1; r0_num_i = 2;
    #1;
    check("r2_still_reserved", reserved_o, 1);
    check("r2_still_busy", busy_o, 8'h04);
    tick();
    idle();
    clr_v_i = 1; clr_num_i = 2;
    tick();
    check("r2_drained", busy_o, 8'h00);
    check("r2_no_err_yet", err_o, 0);
    tick();
    idle();
    check("r2_underflow_err", err_o, 1);
    check("r2_underflow_cnt", busy_o, 8'h00);
    tick(); tick();
    check("err_sticky", err_o, 1);
    check("stall_two", stall_cnt_o, 2);

    // Reset between edges to restart err and stall from zero.
    #2 rst = 1'b0;
    #1;
    check("midrst_err", err_o, 0);
    check("midrst_stall", stall_cnt_o, 0);
    #1 rst = 1'b1;
    tick();

    // Port-use gating and stall counting with cnt[1] = 2.
    set_v_i = 1; set_num_i = 1;
    tick(); tick();
    idle();
    r1_num_i = 1; r1_use_i = 0; r0_use_i = 1; r0_num_i = 0;
    #1;
    check("r1_unused", reserved_o, 0);
    tick();
    r1_use_i = 1;
    #1;
    check("r1_used", reserved_o, 1);
    for (int i = 0; i < 10; i++) tick();
    check("stall_ten", stall_cnt_o, 10);
    clr_v_i = 1; clr_num_i = 1;
    #1;
    check("r1_partial_bypass", reserved_o, 1);
    idle();
    #1;

    // Flush beats a same-cycle set.
    foreach (set_num_i[i]) ;
    set_v_i = 1; set_num_i = 0; tick();
    set_num_i = 4; tick();
    set_num_i = 7; tick();
    set_v_i = 0;
    #1;
    check("pre_flush_busy", busy_o, 8'h93);
    flush_i = 1; set_v_i = 1; set_num_i = 6; r0_use_i = 1; r0_num_i = 0;
    #1;
    check("flush_set_nack", set_ack_o, 0);
    check("flush_no_reserved", reserved_o, 0);
    tick();
    idle();
    #1;
    check("flush_busy", busy_o, 8'h00);
    check("flush_keeps_stall", stall_cnt_o, 10);

    // Build state then reset asynchronously mid-burst.
    clr_v_i = 1; clr_num_i = 2;
    tick();
    clr_v_i = 0; set_v_i = 1; set_num_i = 6;
    tick();
    r0_use_i = 1; r0_num_i = 6;
    #1;
    check("pre_rst_err", err_o, 1);
    check("pre_rst_busy", busy_o, 8'h40);
    #1 rst = 1'b0;
    #1;
    check("async_busy", busy_o, 8'h00);
    check("async_err", err_o, 0);
    check("async_stall", stall_cnt_o, 0);
    check("async_reserved", reserved_o, 0);
    idle();
    #1 rst = 1'b1;
    tick();
    check("post_rst_busy", busy_o, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
